// File: rtl/vga_box_overlay.sv
// vga_box_overlay: draws a hollow cursor box over the VGA pixel stream.
// The box position is loaded by a valid/ready handshake and takes effect at vertical sync.
// Ports: iVGA_CLK/iRST_n (async active-low) clock and reset; iHS/iVS/iBLANK_n and iB/iG/iR
// carry video from the controller; iPOS_X/iPOS_Y/iPOS_VALID/oPOS_READY form the position
// handshake; oHS/oVS/oBLANK_n and oB/oG/oR drive the DAC one clock behind the inputs;
// oFRAME_TICK pulses for one clock when a new position takes effect.
// Optional macro CURSOR_BLINK_EN: blinks the box using bit BLINK_SHIFT of a frame counter.
module vga_box_overlay #(
   parameter int          VIDEO_W = 640,
   parameter int          VIDEO_H = 480,
   parameter int          BOX_W   = 32,
   parameter int          BOX_H   = 32,
   parameter int          BORDER  = 2,
   parameter logic [23:0] BOX_BGR = 24'h00FF00,
   parameter int          INIT_X  = 0,
   parameter int          INIT_Y  = 0
`ifdef CURSOR_BLINK_EN
  ,parameter int          BLINK_SHIFT = 4
`endif
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       iHS,
   input  logic       iVS,
   input  logic       iBLANK_n,
   input  logic [7:0] iB,
   input  logic [7:0] iG,
   input  logic [7:0] iR,
   input  logic [9:0] iPOS_X,
   input  logic [8:0] iPOS_Y,
   input  logic       iPOS_VALID,
   output logic       oPOS_READY,
   output logic       oHS,
   output logic       oVS,
   output logic       oBLANK_n,
   output logic [7:0] oB,
   output logic [7:0] oG,
   output logic [7:0] oR,
   output logic       oFRAME_TICK
);
   localparam logic [9:0] X_MAX = 10'(VIDEO_W - BOX_W);
   localparam logic [8:0] Y_MAX = 9'(VIDEO_H - BOX_H);
   logic [9:0] x_cnt, box_x, pend_x, clamp_x;
   logic [8:0] y_cnt, box_y, pend_y, clamp_y;
   logic pend, vs_d, blank_d, vs_fall, in_box, on_edge, show, draw;
   logic [10:0] px, py, bx, by;
   assign vs_fall    = vs_d & ~iVS;
   assign oPOS_READY = ~pend;
   assign clamp_x    = (iPOS_X > X_MAX) ? X_MAX : iPOS_X;
   assign clamp_y    = (iPOS_Y > Y_MAX) ? Y_MAX : iPOS_Y;
`ifdef CURSOR_BLINK_EN
   logic [7:0] frame_cnt;
   always_ff @(posedge iVGA_CLK or negedge iRST_n)
      if (!iRST_n) frame_cnt <= '0;
      else if (vs_fall) frame_cnt <= frame_cnt + 8'd1;
   assign show = ~frame_cnt[BLINK_SHIFT];
`else
   assign show = 1'b1;
`endif
   // 11-bit arithmetic so bx+BOX_W-1 at the right screen edge cannot wrap to 0
   always_comb begin
      px      = {1'b0, x_cnt};
      py      = {2'b0, y_cnt};
      bx      = {1'b0, box_x};
      by      = {2'b0, box_y};
      in_box  = px >= bx && px <= bx + 11'(BOX_W - 1) && py >= by && py <= by + 11'(BOX_H - 1);
      on_edge = px < bx + 11'(BORDER) || px >= bx + 11'(BOX_W - BORDER) ||
                py < by + 11'(BORDER) || py >= by + 11'(BOX_H - BORDER);
      draw    = iBLANK_n && in_box && on_edge && show;
   end
   always_ff @(posedge iVGA_CLK or negedge iRST_n)
      if (!iRST_n) begin
         oHS         <= 1'b1;
         oVS         <= 1'b1;
         oBLANK_n    <= 1'b0;
         oB          <= '0;
         oG          <= '0;
         oR          <= '0;
         oFRAME_TICK <= 1'b0;
         vs_d        <= 1'b1;
         blank_d     <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         box_x       <= 10'(INIT_X);
         box_y       <= 9'(INIT_Y);
         pend_x      <= '0;
         pend_y      <= '0;
         pend        <= 1'b0;
      end else begin
         oHS         <= iHS;
         oVS         <= iVS;
         oBLANK_n    <= iBLANK_n;
         oB          <= draw ? BOX_BGR[23:16] : iB;
         oG          <= draw ? BOX_BGR[15:8]  : iG;
         oR          <= draw ? BOX_BGR[7:0]   : iR;
         vs_d        <= iVS;
         blank_d     <= iBLANK_n;
         x_cnt       <= iBLANK_n ? x_cnt + 10'd1 : '0;
         y_cnt       <= !iVS ? '0 :
                        (blank_d && !iBLANK_n && y_cnt != 9'(VIDEO_H)) ? y_cnt + 9'd1 : y_cnt;
         // only a request pending before the VS edge is applied; ready is low while pending
         oFRAME_TICK <= vs_fall && pend;
         if (vs_fall && pend) begin
            box_x <= pend_x;
            box_y <= pend_y;
            pend  <= 1'b0;
         end else if (iPOS_VALID && !pend) begin
            pend_x <= clamp_x;
            pend_y <= clamp_y;
            pend   <= 1'b1;
         end
      end
endmodule

// File: tb/tb_vga_box_overlay.sv
// tb_vga_box_overlay: directed self-checking bench for vga_box_overlay.
module tb_vga_box_overlay;
   localparam logic [23:0] BOX  = 24'h00FF00;
   localparam logic [23:0] GREY = 24'h808080;
   logic iVGA_CLK = 0, iRST_n = 0, iHS = 1, iVS = 1, iBLANK_n = 0, iPOS_VALID = 0;
   logic [7:0] iB = 0, iG = 0, iR = 0;
   logic [9:0] iPOS_X = 0;
   logic [8:0] iPOS_Y = 0;
   logic oPOS_READY, oHS, oVS, oBLANK_n, oFRAME_TICK;
   logic [7:0] oB, oG, oR;
   logic [23:0] pix [0:639];
   int n_cmp = 0, n_err = 0, tick_cnt = 0, t0;

   vga_box_overlay dut (
      .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
      .iB(iB), .iG(iG), .iR(iR), .iPOS_X(iPOS_X), .iPOS_Y(iPOS_Y), .iPOS_VALID(iPOS_VALID),
      .oPOS_READY(oPOS_READY), .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
      .oB(oB), .oG(oG), .oR(oR), .oFRAME_TICK(oFRAME_TICK));

   always #5 iVGA_CLK = ~iVGA_CLK;
   always @(negedge iVGA_CLK) if (oFRAME_TICK === 1'b1) tick_cnt++;

   task automatic drive_line(input int n, input logic [23:0] col);
      for (int x = 0; x < n; x++) begin
         iBLANK_n = 1;
         {iB, iG, iR} = col;
         @(negedge iVGA_CLK);
         pix[x] = {oB, oG, oR};
      end
      iBLANK_n = 0;
      {iB, iG, iR} = 0;
      repeat (2) @(negedge iVGA_CLK);
   endtask

   task automatic skip_lines(input int n);
      for (int i = 0; i < n; i++) drive_line(1, GREY);
   endtask

   task automatic vsync;
      iVS = 0;
      repeat (3) @(negedge iVGA_CLK);
      iVS = 1;
      repeat (3) @(negedge iVGA_CLK);
   endtask

   task automatic request(input logic [9:0] x, input logic [8:0] y);
      iPOS_X = x;
      iPOS_Y = y;
      iPOS_VALID = 1;
      @(negedge iVGA_CLK);
      iPOS_VALID = 0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1;
      iBLANK_n = 1;
      iR = 8'hAA;
      iHS = 0;
      repeat (3) @(negedge iVGA_CLK);
      #2 iRST_n = 0;
      #1;
      n_cmp++; if (oR !== 8'h00) begin n_err++; $display("FAIL rst_oR got %h want 00", oR); end
      n_cmp++; if (oHS !== 1'b1) begin n_err++; $display("FAIL rst_oHS got %b want 1", oHS); end
      n_cmp++; if (oVS !== 1'b1) begin n_err++; $display("FAIL rst_oVS got %b want 1", oVS); end
      n_cmp++; if (oBLANK_n !== 1'b0) begin n_err++; $display("FAIL rst_oBLANK_n got %b want 0", oBLANK_n); end
      n_cmp++; if (oPOS_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", oPOS_READY); end
      n_cmp++; if (oFRAME_TICK !== 1'b0) begin n_err++; $display("FAIL rst_tick got %b want 0", oFRAME_TICK); end
      @(negedge iVGA_CLK);
      iRST_n = 1;
      iBLANK_n = 0;
      iR = 0;
      iHS = 1;
      @(negedge iVGA_CLK);
      iHS = 0;
      @(negedge iVGA_CLK);
      n_cmp++; if (oHS !== 1'b0) begin n_err++; $display("FAIL hs_pass got %b want 0", oHS); end
      iHS = 1;
      @(negedge iVGA_CLK);
      drive_line(4, GREY);
      drive_line(4, GREY);
      n_cmp++; if (pix[1] !== BOX) begin n_err++; $display("FAIL init_px_1_1 got %h want %h", pix[1], BOX); end
      drive_line(4, GREY);
      n_cmp++; if (pix[1] !== BOX) begin n_err++; $display("FAIL init_px_1_2 got %h want %h", pix[1], BOX); end
      n_cmp++; if (pix[2] !== GREY) begin n_err++; $display("FAIL init_px_2_2 got %h want %h", pix[2], GREY); end
   endtask

   task automatic test_grey_box;
      n_cmp++; if (oPOS_READY !== 1'b1) begin n_err++; $display("FAIL grey_ready_pre got %b want 1", oPOS_READY); end
      request(100, 50);
      n_cmp++; if (oPOS_READY !== 1'b0) begin n_err++; $display("FAIL grey_ready_post got %b want 0", oPOS_READY); end
      t0 = tick_cnt;
      vsync;
      n_cmp++; if (tick_cnt !== t0 + 1) begin n_err++; $display("FAIL grey_tick got %0d want %0d", tick_cnt, t0 + 1); end
      n_cmp++; if (oPOS_READY !== 1'b1) begin n_err++; $display("FAIL grey_ready_apply got %b want 1", oPOS_READY); end
      skip_lines(50);
      drive_line(140, GREY);
      n_cmp++; if (pix[99] !== GREY) begin n_err++; $display("FAIL grey_99_50 got %h want %h", pix[99], GREY); end
      n_cmp++; if (pix[132] !== GREY) begin n_err++; $display("FAIL grey_132_50 got %h want %h", pix[132], GREY); end
      for (int x = 100; x < 132; x++) begin
         n_cmp++; if (pix[x] !== BOX) begin n_err++; $display("FAIL grey_top x=%0d got %h want %h", x, pix[x], BOX); end
      end
      skip_lines(9);
      drive_line(140, GREY);
      n_cmp++; if (pix[100] !== BOX) begin n_err++; $display("FAIL grey_100_60 got %h want %h", pix[100], BOX); end
      n_cmp++; if (pix[101] !== BOX) begin n_err++; $display("FAIL grey_101_60 got %h want %h", pix[101], BOX); end
      n_cmp++; if (pix[102] !== GREY) begin n_err++; $display("FAIL grey_102_60 got %h want %h", pix[102], GREY); end
      n_cmp++; if (pix[110] !== GREY) begin n_err++; $display("FAIL grey_110_60 got %h want %h", pix[110], GREY); end
      n_cmp++; if (pix[129] !== GREY) begin n_err++; $display("FAIL grey_129_60 got %h want %h", pix[129], GREY); end
      n_cmp++; if (pix[130] !== BOX) begin n_err++; $display("FAIL grey_130_60 got %h want %h", pix[130], BOX); end
      n_cmp++; if (pix[131] !== BOX) begin n_err++; $display("FAIL grey_131_60 got %h want %h", pix[131], BOX); end
   endtask

   task automatic test_clamp;
      request(700, 470);
      vsync;
      skip_lines(479);
      drive_line(640, GREY);
      n_cmp++; if (pix[639] !== BOX) begin n_err++; $display("FAIL clamp_639_479 got %h want %h", pix[639], BOX); end
      n_cmp++; if (pix[608] !== BOX) begin n_err++; $display("FAIL clamp_608_479 got %h want %h", pix[608], BOX); end
      n_cmp++; if (pix[607] !== GREY) begin n_err++; $display("FAIL clamp_607_479 got %h want %h", pix[607], GREY); end
      n_cmp++; if (pix[0] !== GREY) begin n_err++; $display("FAIL clamp_nowrap_0 got %h want %h", pix[0], GREY); end
      drive_line(640, GREY);
      n_cmp++; if (pix[639] !== GREY) begin n_err++; $display("FAIL clamp_sat_line got %h want %h", pix[639], GREY); end
   endtask

   task automatic test_midframe;
      t0 = tick_cnt;
      vsync;
      n_cmp++; if (tick_cnt !== t0) begin n_err++; $display("FAIL mid_no_tick got %0d want %0d", tick_cnt, t0); end
      drive_line(4, GREY);
      request(0, 0);
      n_cmp++; if (oPOS_READY !== 1'b0) begin n_err++; $display("FAIL mid_ready got %b want 0", oPOS_READY); end
      iPOS_X = 300;
      iPOS_Y = 100;
      iPOS_VALID = 1;
      repeat (2) @(negedge iVGA_CLK);
      iPOS_VALID = 0;
      skip_lines(478);
      drive_line(640, GREY);
      n_cmp++; if (pix[639] !== BOX) begin n_err++; $display("FAIL mid_old_box got %h want %h", pix[639], BOX); end
      n_cmp++; if (pix[0] !== GREY) begin n_err++; $display("FAIL mid_old_0 got %h want %h", pix[0], GREY); end
      n_cmp++; if (tick_cnt !== t0) begin n_err++; $display("FAIL mid_early_tick got %0d want %0d", tick_cnt, t0); end
      vsync;
      n_cmp++; if (tick_cnt !== t0 + 1) begin n_err++; $display("FAIL mid_tick got %0d want %0d", tick_cnt, t0 + 1); end
      n_cmp++; if (oPOS_READY !== 1'b1) begin n_err++; $display("FAIL mid_ready_apply got %b want 1", oPOS_READY); end
      drive_line(40, GREY);
      n_cmp++; if (pix[0] !== BOX) begin n_err++; $display("FAIL mid_new_0 got %h want %h", pix[0], BOX); end
      n_cmp++; if (pix[31] !== BOX) begin n_err++; $display("FAIL mid_new_31 got %h want %h", pix[31], BOX); end
      n_cmp++; if (pix[32] !== GREY) begin n_err++; $display("FAIL mid_new_32 got %h want %h", pix[32], GREY); end
      vsync;
      n_cmp++; if (tick_cnt !== t0 + 1) begin n_err++; $display("FAIL mid_ignored_req got %0d want %0d", tick_cnt, t0 + 1); end
   endtask

   task automatic test_same_cycle;
      t0 = tick_cnt;
      iVS = 0;
      iPOS_X = 40;
      iPOS_Y = 0;
      iPOS_VALID = 1;
      @(negedge iVGA_CLK);
      iPOS_VALID = 0;
      repeat (2) @(negedge iVGA_CLK);
      iVS = 1;
      repeat (3) @(negedge iVGA_CLK);
      n_cmp++; if (tick_cnt !== t0) begin n_err++; $display("FAIL same_no_tick got %0d want %0d", tick_cnt, t0); end
      n_cmp++; if (oPOS_READY !== 1'b0) begin n_err++; $display("FAIL same_ready got %b want 0", oPOS_READY); end
      drive_line(80, GREY);
      n_cmp++; if (pix[0] !== BOX) begin n_err++; $display("FAIL same_old_0 got %h want %h", pix[0], BOX); end
      n_cmp++; if (pix[40] !== GREY) begin n_err++; $display("FAIL same_old_40 got %h want %h", pix[40], GREY); end
      vsync;
      n_cmp++; if (tick_cnt !== t0 + 1) begin n_err++; $display("FAIL same_tick got %0d want %0d", tick_cnt, t0 + 1); end
      drive_line(80, GREY);
      n_cmp++; if (pix[40] !== BOX) begin n_err++; $display("FAIL same_new_40 got %h want %h", pix[40], BOX); end
      n_cmp++; if (pix[71] !== BOX) begin n_err++; $display("FAIL same_new_71 got %h want %h", pix[71], BOX); end
      n_cmp++; if (pix[72] !== GREY) begin n_err++; $display("FAIL same_new_72 got %h want %h", pix[72], GREY); end
      n_cmp++; if (pix[0] !== GREY) begin n_err++; $display("FAIL same_new_0 got %h want %h", pix[0], GREY); end
   endtask

   task automatic test_every_frame;
      for (int f = 0; f < 3; f++) begin
         vsync;
         drive_line(80, GREY);
         n_cmp++; if (pix[40] !== BOX) begin n_err++; $display("FAIL frame%0d_box got %h want %h", f, pix[40], BOX); end
      end
   endtask

   initial begin
      test_reset;
      test_grey_box;
      test_clamp;
      test_midframe;
      test_same_cycle;
      test_every_frame;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/vga_box_overlay.md
Name: vga_box_overlay

Overview:
- Post-processing stage directly downstream of the VGA controller.
- Consumes the controller's registered HS/VS/BLANK_n and 8-bit B/G/R pixel stream, and draws a hollow rectangular cursor box over the image.
- Box position is updated by a CPU-side valid/ready handshake and applied only at vertical sync, so the box never tears mid-frame.
- All outputs are one clock behind the inputs and drive the DAC pins.

Parameters:
- VIDEO_W, 640: active pixels per line.
- VIDEO_H, 480: active lines per frame.
- BOX_W, 32: box width in pixels (>= 2*BORDER).
- BOX_H, 32: box height in lines (>= 2*BORDER).
- BORDER, 2: border thickness in pixels/lines.
- BOX_BGR, 24'h00FF00: box colour as {B,G,R}.
- INIT_X, 0: box left edge after reset.
- INIT_Y, 0: box top edge after reset.
- BLINK_SHIFT, 4: frame-counter bit used for blinking (optional feature only).

Ports:
- iVGA_CLK  in  1  pixel clock.
- iRST_n  in  1  reset, asynchronous, active-low.
- iHS  in  1  horizontal sync from controller, active-low.
- iVS  in  1  vertical sync from controller, active-low.
- iBLANK_n  in  1  high during active video.
- iB, iG, iR  in  8 each  input pixel colour.
- iPOS_X  in  10  requested box left edge.
- iPOS_Y  in  9  requested box top edge.
- iPOS_VALID  in  1  position request valid.
- oPOS_READY  out  1  block can accept a new position.
- oHS, oVS, oBLANK_n  out  1 each  delayed syncs/blank.
- oB, oG, oR  out  8 each  output pixel colour.
- oFRAME_TICK  out  1  one-cycle pulse when the new position is applied.

Behaviour:
- Reset (iRST_n=0, asynchronous):
  - oHS=1, oVS=1, oBLANK_n=0, oB/oG/oR=0, oPOS_READY=1, oFRAME_TICK=0.
  - Active box = (INIT_X, INIT_Y); pending flag=0; x/y counters=0; frame counter=0.
  - Reset mid-frame or mid-handshake discards any pending request.
- Pixel X counter (10 bit):
  - Increments on every posedge with iBLANK_n=1.
  - Cleared on any cycle with iBLANK_n=0.
  - X value used for a pixel equals its index within the line, 0..VIDEO_W-1.
- Line Y counter (9 bit):
  - Increments on the iBLANK_n 1->0 edge (end of active line), saturating at VIDEO_H.
  - Cleared while iVS=0.
- Handshake:
  - Transfer occurs when iPOS_VALID=1 and oPOS_READY=1 on a posedge.
  - Captured coordinates are clamped: X to VIDEO_W-BOX_W, Y to VIDEO_H-BOX_H.
  - Captured value goes to the pending registers; pending flag set; oPOS_READY=0 from the next cycle.
  - iPOS_VALID while oPOS_READY=0 is ignored; the requester must hold it.
- Frame update:
  - On the iVS 1->0 edge, if the pending flag was already set before that edge: active box <= pending, pending flag cleared, oPOS_READY=1 and oFRAME_TICK=1 for exactly one cycle on the following cycle.
  - A transfer in the same cycle as the iVS falling edge is held pending and applied at the next frame's VS edge.
  - With no pending request, oFRAME_TICK stays 0.
- Overlay:
  - A pixel is on the border when iBLANK_n=1, X is in [bx, bx+BOX_W-1], Y is in [by, by+BOX_H-1], and it lies within BORDER of any box edge.
  - Border pixels output BOX_BGR; all other pixels pass iB/iG/iR unchanged.
  - Blanked cycles pass input colour unchanged (controller supplies 0).
- Latency:
  - All outputs are registered on posedge, exactly 1 cycle after the inputs, so syncs stay aligned with pixels.
  - Edge comparisons use 11-bit sums; no wrap-around.

Optional Feature:
- CURSOR_BLINK_EN
  - Defined: an 8-bit frame counter increments on each iVS falling edge, wrapping 255->0. The box is drawn only when frame_cnt[BLINK_SHIFT]==0, giving a 2^(BLINK_SHIFT+1)-frame blink period; passthrough otherwise. Counter reset value is 0.
  - Undefined: no counter; the box is always drawn.

Test Plan:
- Reset mid-line with iBLANK_n=1 and iR=8'hAA -> outputs go immediately to 0 / oHS=1 / oVS=1 / oPOS_READY=1; after release, the box is at (0,0) and pixel (1,1) outputs G=8'hFF, R=0, B=0.
- Flat grey input 8'h80, box at (100,50) -> line 50 pixels 100..131 are BOX_BGR; line 60 pixels 100,101,130,131 are BOX_BGR; pixel (110,60) is 8'h80; pixel (99,50) is 8'h80.
- Request (700,470) -> clamped to (608,448); after VS, pixel (639,479) is BOX_BGR and the right border ends exactly at pixel 639 with no wrap to X=0.
- Request accepted mid-frame -> oPOS_READY=0 on the next cycle; the old box is drawn for the rest of the frame; oFRAME_TICK pulses once after the VS falling edge; the new box is drawn from the next frame; a second iPOS_VALID while not ready is not captured.
- Transfer on the same cycle as the iVS falling edge -> no oFRAME_TICK in that frame; the position is applied and the tick pulses at the following VS edge.
- With CURSOR_BLINK_EN and BLINK_SHIFT=0 -> the box is visible on even frames and absent on odd frames; without the macro, it is visible in every frame.
